// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer with 2-entry output queue, redirect flush and fault parking
module fetch_unit #(
  parameter int          MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  output logic        fault,
  output logic [63:0] fault_pc
);

  typedef enum logic {RUN, FAULT} state_t;

  // Highest legal byte address, widened so the bounds compare cannot wrap.
  localparam logic [64:0] LAST_BYTE = 65'(MEM_SIZE - 1);

  state_t      state;
  logic [63:0] fetch_pc;

  logic [31:0] q_instr [2];
  logic [63:0] q_pc    [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        bad;
  logic        deq;
  logic        enq;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];

  // Fetch legality check and queue handshake decisions for this cycle.
  always_comb begin
    bad = (fetch_pc[1:0] != 2'b00) || (({1'b0, fetch_pc} + 65'd3) > LAST_BYTE);
    deq = out_valid && out_ready;
    enq = (state == RUN) && !redirect && !bad && ((count < 2'd2) || deq);
  end

  // Sequencer: owns fetch_pc, the RUN/FAULT state and the fault reporting registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= 64'h0;
    end else if (redirect) begin
      state    <= RUN;
      fetch_pc <= redirect_pc;
      fault    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bad) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= fetch_pc;
          end else if (enq) begin
            fetch_pc <= fetch_pc + 64'd4;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Output queue: dequeue always honoured, redirect then discards whatever remains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      q_instr[0] <= 32'h0;
      q_instr[1] <= 32'h0;
      q_pc[0]    <= 64'h0;
      q_pc[1]    <= 64'h0;
    end else if (redirect) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        q_instr[wr_ptr] <= imem_instr;
        q_pc[wr_ptr]    <= fetch_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        fault;
  logic [63:0] fault_pc;

  int checks = 0;
  int failures = 0;

  logic [95:0] sb[$];

  fetch_unit #(.MEM_SIZE(1024), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .fault(fault),
    .fault_pc(fault_pc)
  );

  // ROM model: word i holds value i.
  assign imem_instr = imem_addr[33:2];

  always #5 clk = ~clk;

  function automatic void push_exp(input logic [63:0] pc);
    sb.push_back({pc, pc[33:2]});
  endfunction

  // Advance one clock; any transfer seen before the edge is scored against the queue.
  task automatic step();
    logic [95:0] exp;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_xfer got pc=%h instr=%h required none", out_pc, out_instr);
      end else begin
        exp = sb.pop_front();
        if ({out_pc, out_instr} !== exp) begin
          failures++;
          $display("FAIL xfer got pc=%h instr=%h required pc=%h instr=%h",
                   out_pc, out_instr, exp[95:32], exp[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 64'h0;
    out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 64'h0;
    out_ready = 1'b0;
    #3;
    checks++;
    if ({out_valid, fault, fault_pc, imem_addr} !== {1'b0, 1'b0, 64'h0, 64'h0}) begin
      failures++;
      $display("FAIL reset_state got v=%b f=%b fpc=%h addr=%h required 0 0 0 0",
               out_valid, fault, fault_pc, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(64'(i * 4));
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
      failures++;
      $display("FAIL seq_first got v=%b pc=%h required 1 0", out_valid, out_pc);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (fault !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_stream got fault=%b v=%b required 0 1", fault, out_valid);
      end
    end
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL seq_drain got left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || imem_addr !== 64'h8) begin
      failures++;
      $display("FAIL bp_stall got v=%b pc=%h addr=%h required 1 0 8", out_valid, out_pc, imem_addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(64'(i * 4));
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bp_release got left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 64'h10;
    step();
    redirect = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h10 || imem_addr !== 64'h18) begin
      failures++;
      $display("FAIL flush_setup got v=%b pc=%h addr=%h required 1 10 18", out_valid, out_pc, imem_addr);
    end
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h40;
    push_exp(64'h10);
    step();
    redirect = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble got v=%b required 0", out_valid);
    end
    push_exp(64'h40);
    push_exp(64'h44);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40) begin
      failures++;
      $display("FAIL flush_target got v=%b pc=%h required 1 40", out_valid, out_pc);
    end
    step();
    step();
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL flush_drain got left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_end_of_memory();
    do_reset();
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h3F8;
    step();
    redirect = 1'b0;
    push_exp(64'h3F8);
    push_exp(64'h3FC);
    step();
    step();
    step();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 64'h400 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL eom_fault got f=%b fpc=%h v=%b required 1 400 0", fault, fault_pc, out_valid);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h400) begin
      failures++;
      $display("FAIL eom_park got f=%b v=%b addr=%h required 1 0 400", fault, out_valid, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 64'h0;
    step();
    redirect = 1'b0;
    checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0 || fault_pc !== 64'h400) begin
      failures++;
      $display("FAIL eom_exit got f=%b v=%b fpc=%h required 0 0 400", fault, out_valid, fault_pc);
    end
    push_exp(64'h0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
      failures++;
      $display("FAIL eom_resume got v=%b pc=%h required 1 0", out_valid, out_pc);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL eom_drain got left=%0d required 0", sb.size());
    end
  endtask

  task automatic test_bad_targets();
    do_reset();
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h42;
    step();
    redirect = 1'b0;
    step();
    step();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 64'h42 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign got f=%b fpc=%h v=%b required 1 42 0", fault, fault_pc, out_valid);
    end
    redirect = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    step();
    checks++;
    if (fault !== 1'b1 || fault_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL overflow got f=%b fpc=%h v=%b required 1 fffffffffffffffc 0", fault, fault_pc, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 64'h3F8;
    step();
    redirect = 1'b0;
    step();
    step();
    step();
    checks++;
    if (fault !== 1'b1 || out_valid !== 1'b1 || out_pc !== 64'h3F8) begin
      failures++;
      $display("FAIL midrst_setup got f=%b v=%b pc=%h required 1 1 3f8", fault, out_valid, out_pc);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, fault, fault_pc, imem_addr} !== {1'b0, 1'b0, 64'h0, 64'h0}) begin
      failures++;
      $display("FAIL midrst_async got v=%b f=%b fpc=%h addr=%h required 0 0 0 0",
               out_valid, fault, fault_pc, imem_addr);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    push_exp(64'h0);
    push_exp(64'h4);
    push_exp(64'h8);
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL midrst_resume got left=%0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_end_of_memory();
    test_bad_targets();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
